// File: rtl/buzzer_pkg.sv
// Shared defaults and sizing helpers for the buzzer tone generator.
package buzzer_pkg;

  localparam int unsigned CLK_HZ_DEF  = 50_000_000;
  localparam int unsigned TICK_HZ_DEF = 1_000_000;
  localparam int unsigned CNT_W_DEF   = 16;

  function automatic int unsigned prescale_f(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PRESCALE = prescale_f(CLK_HZ_DEF, TICK_HZ_DEF);

  typedef enum logic [1:0] {
    TONE_IDLE,
    TONE_HOLD,
    TONE_COUNT,
    TONE_TOGGLE
  } tone_op_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick strobe every DIV clocks.
module tick_prescaler #(
  parameter int unsigned DIV = buzzer_pkg::PRESCALE
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned P_W = buzzer_pkg::cnt_bits(DIV);
  localparam logic [P_W-1:0] P_LAST = P_W'(DIV - 1);

  logic [P_W-1:0] p;
  logic [P_W-1:0] p_next;

  always_comb begin
    p_next = p + 1'b1;
    if (p == P_LAST) p_next = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) p <= '0;
    else         p <= p_next;
  end

  // Gated by reset so no strobe escapes while the block is held.
  assign tick_o = (p == P_LAST) && rst_ni;

endmodule

// File: rtl/buzzer_tone_divider.sv
// Programmable square-wave tone core driven by a 1 MHz clock-enable tick.
// Optional complement output enabled by defining BUZZER_COMPLEMENT_EN.
module buzzer_tone_divider
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ = TICK_HZ_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             tick_o,
  output logic             freq_o
`ifdef BUZZER_COMPLEMENT_EN
  ,
  output logic             freq_n_o
`endif
);

  localparam int unsigned DIV = prescale_f(CLK_HZ, TICK_HZ);

  if (DIV < 2) begin : g_bad_prescale
    $error("buzzer_tone_divider: CLK_HZ/TICK_HZ must be at least 2");
  end

  tick_prescaler #(
    .DIV(DIV)
  ) u_tick_prescaler (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tick_o(tick_o)
  );

  tone_op_e         op;
  logic [CNT_W-1:0] c;
  logic [CNT_W-1:0] c_next;
  logic             freq_q;
  logic             freq_next;

  // Compare is >= so a lowered count_i ends the half-period on the next tick
  // instead of wrapping the counter through 2^CNT_W.
  always_comb begin
    op = TONE_HOLD;
    if (!en_i)              op = TONE_IDLE;
    else if (!tick_o)       op = TONE_HOLD;
    else if (c >= count_i)  op = TONE_TOGGLE;
    else                    op = TONE_COUNT;
  end

  always_comb begin
    c_next    = c;
    freq_next = freq_q;
    case (op)
      TONE_IDLE: begin
        c_next    = '0;
        freq_next = 1'b0;
      end
      TONE_COUNT:  c_next = c + 1'b1;
      TONE_TOGGLE: begin
        c_next    = '0;
        freq_next = ~freq_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c      <= '0;
      freq_q <= 1'b0;
    end else begin
      c      <= c_next;
      freq_q <= freq_next;
    end
  end

  assign freq_o = freq_q;

`ifdef BUZZER_COMPLEMENT_EN
  logic freq_n_q;

  // Both piezo legs rest low when idle rather than holding a DC bias.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) freq_n_q <= 1'b0;
    else         freq_n_q <= en_i & ~freq_next;
  end

  assign freq_n_o = freq_n_q;
`endif

endmodule

// File: tb/tb_buzzer_tone_divider.sv
// Directed bench for buzzer_tone_divider; edge numbers count from reset release.
module tb_buzzer_tone_divider;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             freq;
`ifdef BUZZER_COMPLEMENT_EN
  logic             freq_n;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  buzzer_tone_divider #(
    .CLK_HZ (50_000_000),
    .TICK_HZ(1_000_000),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .count_i (count),
    .tick_o  (tick),
    .freq_o  (freq)
`ifdef BUZZER_COMPLEMENT_EN
    ,
    .freq_n_o(freq_n)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to just after rising edge number 'target', then settle 1 time unit.
  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    count = '0;

    // Reset and free-running prescaler
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_freq", 32'(freq), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    goto(48);  chk("tick_48", 32'(tick), 32'd0);
    goto(49);  chk("tick_49", 32'(tick), 32'd1);
    goto(50);  chk("tick_50", 32'(tick), 32'd0);
    goto(99);  chk("tick_99", 32'(tick), 32'd1);
    goto(149); chk("tick_149", 32'(tick), 32'd1);
    chk("idle_freq", 32'(freq), 32'd0);

    // count_i=0: toggle on every tick
    goto(150);
    en    = 1'b1;
    count = 16'd0;
    goto(199); chk("c0_pre", 32'(freq), 32'd0);
`ifdef BUZZER_COMPLEMENT_EN
    chk("c0_fn_lo", 32'(freq_n), 32'd1);
`endif
    goto(200); chk("c0_rise", 32'(freq), 32'd1);
`ifdef BUZZER_COMPLEMENT_EN
    chk("c0_fn_hi", 32'(freq_n), 32'd0);
`endif
    goto(249); chk("c0_hold", 32'(freq), 32'd1);
    goto(250); chk("c0_fall", 32'(freq), 32'd0);
    goto(300); chk("c0_rise2", 32'(freq), 32'd1);

    // A4: half-period 1136 ticks = 56_800 clk from the toggle at edge 300
    count = 16'd1135;
    goto(30000); chk("a4_mid", 32'(freq), 32'd1);
    goto(57099); chk("a4_pre", 32'(freq), 32'd1);
    goto(57100); chk("a4_fall", 32'(freq), 32'd0);

    // Lower count_i below c mid half-period
    count = 16'd1000;
    goto(62100);
    count = 16'd10;
    goto(62149); chk("lo_pre", 32'(freq), 32'd0);
    goto(62150); chk("lo_rise", 32'(freq), 32'd1);
    goto(62699); chk("lo_hold", 32'(freq), 32'd1);
    goto(62700); chk("lo_fall", 32'(freq), 32'd0);
    goto(63249); chk("lo_hold2", 32'(freq), 32'd0);
    goto(63250); chk("lo_rise2", 32'(freq), 32'd1);

    // Enable drop mid half-period, then re-enable with count_i=3
    goto(63410); chk("dis_pre", 32'(freq), 32'd1);
    en = 1'b0;
    goto(63411); chk("dis_freq", 32'(freq), 32'd0);
`ifdef BUZZER_COMPLEMENT_EN
    chk("dis_fn", 32'(freq_n), 32'd0);
`endif
    goto(63420); chk("dis_tick", 32'(freq), 32'd0);
    en    = 1'b1;
    count = 16'd3;
`ifdef BUZZER_COMPLEMENT_EN
    goto(63421); chk("ren_fn", 32'(freq_n), 32'd1);
`endif
    goto(63599); chk("ren_pre", 32'(freq), 32'd0);
    goto(63600); chk("ren_rise", 32'(freq), 32'd1);

    // Reset mid-tone, landing on a tick cycle
    goto(63649); chk("mr_tick", 32'(tick), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_tick_gate", 32'(tick), 32'd0);
    goto(63650); chk("mr_freq", 32'(freq), 32'd0);
    chk("mr_tick_hold", 32'(tick), 32'd0);
`ifdef BUZZER_COMPLEMENT_EN
    chk("mr_fn", 32'(freq_n), 32'd0);
`endif
    goto(63655);
    rst_n = 1'b1;
    goto(63703); chk("rr_tick_pre", 32'(tick), 32'd0);
    goto(63704); chk("rr_tick", 32'(tick), 32'd1);
    goto(63854); chk("rr_pre", 32'(freq), 32'd0);
    goto(63855); chk("rr_rise", 32'(freq), 32'd1);
`ifdef BUZZER_COMPLEMENT_EN
    chk("rr_fn", 32'(freq_n), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
